mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single 16-bit main-memory port between the instruction cache and the data cache miss/writeback paths of the pipelined processor. Sequences one memory transaction at a time, alternates grants under contention, watches for a stuck memory via a timeout, and keeps saturating grant and conflict counters for the performance log. Sits between the two cache controllers and the memory model, below the fetch and memory stages.

## Interface
- CNT_W, 16: width of performance counters.
- TIMEOUT, 64: cycles to wait for mem_done before aborting; 0 disables the watchdog.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache request; level, held until i_done.
- i_addr  in  16  I-cache word address.
- i_done  out  1  one-cycle completion pulse to I-cache.
- i_rdata  out  16  read data, valid only while i_done is high.
- d_req  in  1  D-cache request; level, held until d_done.
- d_wr  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  16  D-cache word address.
- d_wdata  in  16  D-cache write data.
- d_done  out  1  one-cycle completion pulse to D-cache.
- d_rdata  out  16  read data, valid only while d_done is high.
- err  out  1  high together with i_done or d_done when that completion is a timeout abort.
- mem_req  out  1  memory request; registered, held until mem_done or abort.
- mem_wr  out  1  write enable to memory.
- mem_addr  out  16  memory address, registered at grant.
- mem_wdata  out  16  memory write data, registered at grant.
- mem_done  in  1  one-cycle memory completion.
- mem_rdata  in  16  memory read data, valid with mem_done.
- busy  out  1  state is not IDLE.
- i_grant_cnt  out  CNT_W  I-cache grants since reset.
- d_grant_cnt  out  CNT_W  D-cache grants since reset.
- conflict_cnt  out  CNT_W  IDLE cycles in which both requests were high.

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester that was not granted last and increment conflict_cnt. last_grant resets to I, so the first tie goes to D. On grant, latch addr/wr/wdata into the mem_* registers (mem_wr forced to 0 for I) and increment that requester's grant counter.
- BUSY_x: mem_req=1.
  - On mem_done: pulse x_done combinationally that cycle. x_rdata = mem_rdata; the other rdata is 0. Return to IDLE.
  - Watchdog counter, when TIMEOUT>0: counts cycles in BUSY. If it reaches TIMEOUT-1 without mem_done, pulse x_done and err in that cycle, with x_rdata=0, then return to IDLE.
- Requester protocol: the requester drops req on the edge at which done was high. A req still high in the following IDLE cycle is a new request.
- mem_done in IDLE is ignored: no done pulse, no state change.
- Counters saturate at all-ones and never wrap.
- Reset values:
  - All outputs are 0 while rst_n is low or immediately after.
  - state=IDLE, last_grant=I, watchdog=0, all counters 0.
  - Assertion of rst_n mid-transaction drops mem_req asynchronously. The in-flight access is abandoned and no done pulse is issued.

## Timing
- Req high in IDLE during cycle N → mem_req high from cycle N+1.
- mem_done in cycle M → x_done in cycle M, IDLE in cycle M+1.
- Earliest next grant is in cycle M+1. Minimum transaction period is 2 cycles; maximum is TIMEOUT+1 cycles.
- mem_addr, mem_wr and mem_wdata are stable for the entire BUSY interval.
- With both requesters continuously requesting, grants strictly alternate I/D after the first.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY_I, BUSY_D};
  - owner enum {OWN_I, OWN_D};
  - default CNT_W and TIMEOUT constants.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, q), instantiated three times for the performance counters. The watchdog is inline.

## Test plan
- I read only: i_req, i_addr=0x0040; memory answers mem_done after 3 cycles with 0xBEEF → mem_req from the next cycle; mem_addr=0x0040, mem_wr=0; i_done plus i_rdata=0xBEEF in the mem_done cycle; i_grant_cnt=1.
- D write: d_req, d_wr=1, d_addr=0x1000, d_wdata=0x1234 → mem_wr=1, mem_wdata=0x1234 held until mem_done; then d_done; err=0.
- Simultaneous requests for 4 transactions → grant order D, I, D, I; conflict_cnt counts each tied IDLE cycle; no lost or duplicated done pulses.
- TIMEOUT=8, memory never responds → d_done and err pulse 8 cycles after grant; d_rdata=0; arbiter returns to IDLE and the next i_req is granted normally.
- Reset mid-BUSY: assert rst_n low during BUSY_D, then deliver mem_done after release → no d_done; counters 0; mem_req 0; spurious mem_done ignored.
- Saturation with CNT_W=2: 5 I grants → i_grant_cnt stays at 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   localparam int CNT_W_DEF   = 16;
   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between I-cache and D-cache: one transaction at a
// time, alternating priority on ties, watchdog abort, saturating counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_req,
   input  logic [15:0]      i_addr,
   output logic             i_done,
   output logic [15:0]      i_rdata,
   input  logic             d_req,
   input  logic             d_wr,
   input  logic [15:0]      d_addr,
   input  logic [15:0]      d_wdata,
   output logic             d_done,
   output logic [15:0]      d_rdata,
   output logic             err,
   output logic             mem_req,
   output logic             mem_wr,
   output logic [15:0]      mem_addr,
   output logic [15:0]      mem_wdata,
   input  logic             mem_done,
   input  logic [15:0]      mem_rdata,
   output logic             busy,
   output logic [CNT_W-1:0] i_grant_cnt,
   output logic [CNT_W-1:0] d_grant_cnt,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

   state_e          state_q;
   owner_e          last_q;
   logic [WD_W-1:0] wd_q;
   logic            mem_req_q;
   logic            mem_wr_q;
   logic [15:0]     mem_addr_q;
   logic [15:0]     mem_wdata_q;

   logic idle, in_i, in_d, tmo, finish, tie, grant_i, grant_d;

   assign idle    = (state_q == IDLE);
   assign in_i    = (state_q == BUSY_I);
   assign in_d    = (state_q == BUSY_D);
   // A real completion in the last watchdog cycle wins over the abort.
   assign tmo     = (TIMEOUT > 0) && !idle && !mem_done && (wd_q == WD_LAST);
   assign finish  = !idle && (mem_done || tmo);
   assign tie     = idle && i_req && d_req;
   assign grant_i = idle && i_req && (!d_req || (last_q == OWN_D));
   assign grant_d = idle && d_req && (!i_req || (last_q == OWN_I));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= OWN_I;
         wd_q        <= '0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               wd_q <= '0;
               if (grant_i) begin
                  state_q     <= BUSY_I;
                  last_q      <= OWN_I;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= 1'b0;
                  mem_addr_q  <= i_addr;
                  mem_wdata_q <= '0;
               end else if (grant_d) begin
                  state_q     <= BUSY_D;
                  last_q      <= OWN_D;
                  mem_req_q   <= 1'b1;
                  mem_wr_q    <= d_wr;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
               end
            end
            default: begin
               if (finish) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  mem_wr_q  <= 1'b0;
                  wd_q      <= '0;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
         endcase
      end
   end

   assign i_done    = in_i && finish;
   assign d_done    = in_d && finish;
   assign err       = tmo;
   assign i_rdata   = (in_i && mem_done) ? mem_rdata : '0;
   assign d_rdata   = (in_d && mem_done) ? mem_rdata : '0;
   assign mem_req   = mem_req_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = !idle;

   sat_counter #(.W(CNT_W)) u_i_grant_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (grant_i),
      .q     (i_grant_cnt)
   );

   sat_counter #(.W(CNT_W)) u_d_grant_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (grant_d),
      .q     (d_grant_cnt)
   );

   sat_counter #(.W(CNT_W)) u_conflict_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (tie),
      .q     (conflict_cnt)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model with directed and
// randomized requester/memory behaviour; a 2-bit-counter twin shares the inputs.
module tb_mem_arbiter;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, d_req, d_wr, mem_done;
   logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;

   logic        i_done, d_done, err, mem_req, mem_wr, busy;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [15:0] i_grant_cnt, d_grant_cnt, conflict_cnt;

   logic        b_i_done, b_d_done, b_err, b_mem_req, b_mem_wr, b_busy;
   logic [15:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
   logic [1:0]  b_i_grant_cnt, b_d_grant_cnt, b_conflict_cnt;

   mem_arbiter #(.CNT_W(16), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .err(err),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy),
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .conflict_cnt(conflict_cnt)
   );

   mem_arbiter #(.CNT_W(2), .TIMEOUT(TMO)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_done(b_i_done), .i_rdata(b_i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(b_d_done), .d_rdata(b_d_rdata), .err(b_err),
      .mem_req(b_mem_req), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(b_busy),
      .i_grant_cnt(b_i_grant_cnt), .d_grant_cnt(b_d_grant_cnt), .conflict_cnt(b_conflict_cnt)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Requester-side view and reference model state.
   bit          i_pend, d_pend, d_w, last_d, win_d;
   logic [15:0] i_a, d_a, d_wd;
   int          m_igr, m_dgr, m_conf;
   bit          exp_ord [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   function automatic int sat(input int v, input int w);
      int m;
      m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive();
      i_req   = i_pend;
      i_addr  = i_a;
      d_req   = d_pend;
      d_wr    = d_w;
      d_addr  = d_a;
      d_wdata = d_wd;
   endtask

   task automatic chk_counters();
      chk("i_grant_cnt",    32'(i_grant_cnt),    32'(sat(m_igr, 16)));
      chk("d_grant_cnt",    32'(d_grant_cnt),    32'(sat(m_dgr, 16)));
      chk("conflict_cnt",   32'(conflict_cnt),   32'(sat(m_conf, 16)));
      chk("b_i_grant_cnt",  32'(b_i_grant_cnt),  32'(sat(m_igr, 2)));
      chk("b_d_grant_cnt",  32'(b_d_grant_cnt),  32'(sat(m_dgr, 2)));
      chk("b_conflict_cnt", 32'(b_conflict_cnt), 32'(sat(m_conf, 2)));
   endtask

   // One arbitration round; called just after a rising edge with DUT idle and
   // at least one request pending. lat > TMO means the memory never answers.
   task automatic do_round(input int lat, input logic [15:0] rd);
      logic [15:0] ea, ew;
      logic        ewr, tmo_e, fin;
      int          n_end;
      @(negedge clk);
      chk("idle_busy", 32'({busy, mem_req, b_busy, b_mem_req}), 32'd0);
      chk("idle_done", 32'({i_done, d_done, err}), 32'd0);
      chk_counters();
      if (i_pend && d_pend) begin
         win_d = !last_d;
         m_conf++;
      end else begin
         win_d = d_pend;
      end
      @(posedge clk); #1;
      if (win_d) m_dgr++; else m_igr++;
      last_d = win_d;
      ea    = win_d ? d_a : i_a;
      ewr   = win_d ? d_w : 1'b0;
      ew    = win_d ? d_wd : 16'd0;
      tmo_e = (lat > TMO);
      n_end = tmo_e ? TMO : lat;
      for (int k = 1; k <= n_end; k++) begin
         fin       = (k == n_end);
         mem_done  = !tmo_e && fin;
         mem_rdata = fin ? rd : 16'($urandom);
         @(negedge clk);
         chk("busy_req",  32'({busy, mem_req, b_busy, b_mem_req}), 32'hF);
         chk("mem_bus",   {mem_addr, mem_wdata}, {ea, ew});
         chk("b_mem_bus", {b_mem_addr, b_mem_wdata}, {ea, ew});
         chk("mem_wr",    32'({mem_wr, b_mem_wr}), 32'({ewr, ewr}));
         chk("i_done",    32'({i_done, b_i_done}), (fin && !win_d) ? 32'h3 : 32'h0);
         chk("d_done",    32'({d_done, b_d_done}), (fin && win_d) ? 32'h3 : 32'h0);
         chk("err",       32'({err, b_err}), (fin && tmo_e) ? 32'h3 : 32'h0);
         chk("i_rdata",   {i_rdata, b_i_rdata}, (fin && !tmo_e && !win_d) ? {rd, rd} : 32'h0);
         chk("d_rdata",   {d_rdata, b_d_rdata}, (fin && !tmo_e && win_d) ? {rd, rd} : 32'h0);
         @(posedge clk); #1;
      end
      mem_done = 1'b0;
      if (win_d) d_pend = 1'b0; else i_pend = 1'b0;
      drive();
   endtask

   // No requests: the arbiter must ignore stray mem_done pulses.
   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         mem_done  = 1'($urandom);
         mem_rdata = 16'($urandom);
         @(negedge clk);
         chk("idle_quiet", 32'({busy, mem_req, i_done, d_done, err, b_busy, b_i_done, b_d_done}), 32'd0);
         chk("idle_rdata", {i_rdata, d_rdata}, 32'd0);
         @(posedge clk); #1;
      end
      mem_done = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL time_limit: simulation did not complete");
      $fatal(1, "time limit reached");
   end

   initial begin
      rst_n = 1'b0;
      i_pend = 0; d_pend = 0; d_w = 0; last_d = 0;
      i_a = '0; d_a = '0; d_wd = '0;
      m_igr = 0; m_dgr = 0; m_conf = 0;
      mem_done = 1'b0; mem_rdata = '0;
      drive();
      repeat (2) @(negedge clk);
      chk("rst_outputs", 32'({busy, mem_req, mem_wr, i_done, d_done, err}), 32'd0);
      chk("rst_bus", {mem_addr, mem_wdata}, 32'd0);
      chk_counters();
      @(posedge clk); #1 rst_n = 1'b1;

      // Both requesters keep asking: first tie goes to D, then strict alternation.
      i_pend = 1; i_a = 16'h0100; d_pend = 1; d_a = 16'h0200; d_w = 0; d_wd = 16'h0;
      drive();
      for (int t = 0; t < 4; t++) begin
         do_round(2, 16'($urandom));
         chk("tie_order", 32'(last_d), 32'(exp_ord[t]));
         if (t < 3) begin
            if (last_d) begin d_pend = 1; d_a = d_a + 16'd1; end
            else begin i_pend = 1; i_a = i_a + 16'd1; end
            drive();
         end
      end
      chk("tie_conflicts", 32'(conflict_cnt), 32'd4);
      do_round(1, 16'h0F0F);

      i_pend = 1; i_a = 16'h0040; drive();
      do_round(3, 16'hBEEF);
      d_pend = 1; d_w = 1; d_a = 16'h1000; d_wd = 16'h1234; drive();
      do_round(4, 16'h5555);
      d_pend = 1; d_w = 0; d_a = 16'h2000; d_wd = 16'h0; drive();
      do_round(100, 16'hAAAA);
      i_pend = 1; i_a = 16'h0041; drive();
      do_round(2, 16'h1111);
      idle_cycles(3);

      // Reset while D transaction is in flight, then a late mem_done.
      d_pend = 1; d_w = 1; d_a = 16'h3000; d_wd = 16'h7777; drive();
      @(posedge clk); #1;
      @(negedge clk);
      chk("rb_busy", 32'({busy, mem_req, mem_wr}), 32'h7);
      #1 rst_n = 1'b0;
      #1;
      m_igr = 0; m_dgr = 0; m_conf = 0; last_d = 0;
      chk("rb_async", 32'({busy, mem_req, b_mem_req, d_done, i_done, err}), 32'd0);
      chk_counters();
      d_pend = 0; drive();
      @(posedge clk); #1 rst_n = 1'b1;
      mem_done = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      chk("rb_spurious", 32'({busy, mem_req, i_done, d_done, err, b_d_done}), 32'd0);
      chk("rb_rdata", {i_rdata, d_rdata}, 32'd0);
      @(posedge clk); #1 mem_done = 1'b0;
      idle_cycles(1);

      for (int s = 0; s < 5; s++) begin
         i_pend = 1; i_a = 16'($urandom); drive();
         do_round($urandom_range(1, 3), 16'($urandom));
      end
      chk("sat_b_i_grant", 32'(b_i_grant_cnt), 32'd3);
      chk("sat_a_i_grant", 32'(i_grant_cnt), 32'd5);

      for (int r = 0; r < 300; r++) begin
         if (!i_pend && ($urandom_range(0, 2) != 0)) begin
            i_pend = 1; i_a = 16'($urandom);
         end
         if (!d_pend && ($urandom_range(0, 2) != 0)) begin
            d_pend = 1; d_w = 1'($urandom); d_a = 16'($urandom); d_wd = 16'($urandom);
         end
         drive();
         if (!i_pend && !d_pend) idle_cycles($urandom_range(1, 2));
         else do_round($urandom_range(1, TMO + 2), 16'($urandom));
      end
      @(negedge clk);
      chk_counters();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
